// File: rtl/alpha_level_solver_if.sv
// alpha_level_solver_if: request/result handshake bundle for the alpha level solver
interface alpha_level_solver_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] pixel_in;
  logic [7:0] target_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alpha_out;
  logic [7:0] pixel_achieved;
  logic       exact;
  modport master (
    output in_valid, pixel_in, target_in, out_ready,
    input  in_ready, out_valid, alpha_out, pixel_achieved, exact
  );
  modport slave (
    input  in_valid, pixel_in, target_in, out_ready,
    output in_ready, out_valid, alpha_out, pixel_achieved, exact
  );
endinterface

// File: rtl/alpha_level_solver.sv
// alpha_level_solver: binary search for the smallest alpha whose level-adjust output reaches a target
module alpha_level_solver #(
  parameter bit PIPE_EVAL = 1'b0
) (
  input logic clk,
  input logic rst,
  alpha_level_solver_if.slave s
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t     state, state_n;
  logic [7:0] p, t, p_n, t_n, alpha, alpha_n, pix, pix_n, f_c, f_q, fv, lh_sum;
  logic [6:0] lo, hi, lo_n, hi_n, mid, a;
  logic       ex, ex_n, ph, ph_n, go;
  function automatic logic [7:0] curve(input logic [7:0] x, input logic [6:0] k);
    logic        low;
    logic [7:0]  inv;
    logic [6:0]  ka;
    logic [15:0] prod, d;
    logic [31:0] sc;
    logic [16:0] sum;
    low  = k <= 7'd50;
    inv  = 8'd255 - x;
    ka   = k - 7'd50;
    prod = low ? {8'd0, x} * {9'd0, k} : {8'd0, inv} * {9'd0, ka};
    sc   = {16'd0, prod} * 32'd1311;
    d    = 16'(sc >> 16);
    sum  = low ? {1'b0, d} : {9'd0, x} + {1'b0, d};
    return sum > 17'd255 ? 8'd255 : sum[7:0];
  endfunction
  assign lh_sum = {1'b0, lo} + {1'b0, hi};
  assign mid    = lh_sum[7:1];
  assign a      = lo == hi ? lo : mid;
  assign f_c    = curve(p, a);
  // With the registered evaluation, only the second cycle of each pair acts, on the stored curve value
  assign go     = !PIPE_EVAL || ph;
  assign fv     = PIPE_EVAL ? f_q : f_c;
  assign s.in_ready       = state == IDLE;
  assign s.out_valid      = state == DONE;
  assign s.alpha_out      = alpha;
  assign s.pixel_achieved = pix;
  assign s.exact          = ex;
  // Next-state and search-step logic
  always_comb begin
    state_n = state;
    p_n     = p;
    t_n     = t;
    lo_n    = lo;
    hi_n    = hi;
    alpha_n = alpha;
    pix_n   = pix;
    ex_n    = ex;
    ph_n    = 1'b0;
    case (state)
      IDLE: if (s.in_valid) begin
        p_n     = s.pixel_in;
        t_n     = s.target_in;
        lo_n    = 7'd0;
        hi_n    = 7'd100;
        state_n = SEARCH;
      end
      SEARCH: begin
        ph_n = PIPE_EVAL ? !ph : 1'b0;
        if (go) begin
          if (lo == hi) begin
            alpha_n = {1'b0, lo};
            pix_n   = fv;
            ex_n    = fv == t;
            state_n = DONE;
          end else if (fv >= t) hi_n = mid;
          else lo_n = mid + 7'd1;
        end
      end
      DONE: state_n = s.out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p     <= '0;
      t     <= '0;
      lo    <= '0;
      hi    <= '0;
      alpha <= '0;
      pix   <= '0;
      ex    <= 1'b0;
      ph    <= 1'b0;
      f_q   <= '0;
    end else begin
      state <= state_n;
      p     <= p_n;
      t     <= t_n;
      lo    <= lo_n;
      hi    <= hi_n;
      alpha <= alpha_n;
      pix   <= pix_n;
      ex    <= ex_n;
      ph    <= ph_n;
      f_q   <= f_c;
    end
  end
endmodule

// File: tb/tb_alpha_level_solver.sv
// tb_alpha_level_solver: directed and swept checks of both evaluation modes against a brute-force curve model
module tb_alpha_level_solver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] pixel = '0;
  logic [7:0] target = '0;
  int         n_tests = 0;
  int         n_fail = 0;
  alpha_level_solver_if m0 ();
  alpha_level_solver_if m1 ();
  assign m0.in_valid  = in_valid;
  assign m0.pixel_in  = pixel;
  assign m0.target_in = target;
  assign m0.out_ready = out_ready;
  assign m1.in_valid  = in_valid;
  assign m1.pixel_in  = pixel;
  assign m1.target_in = target;
  assign m1.out_ready = out_ready;
  alpha_level_solver #(.PIPE_EVAL(1'b0)) u0 (.clk(clk), .rst(rst), .s(m0));
  alpha_level_solver #(.PIPE_EVAL(1'b1)) u1 (.clk(clk), .rst(rst), .s(m1));
  always #5 clk = ~clk;
  function automatic int fm(int p, int a);
    int d;
    if (a <= 50) d = (p * a * 1311) >>> 16;
    else d = p + (((255 - p) * (a - 50) * 1311) >>> 16);
    return d > 255 ? 255 : d;
  endfunction
  function automatic int best(int p, int t);
    for (int a = 0; a <= 100; a++) if (fm(p, a) >= t) return a;
    return 100;
  endfunction
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input int v, input int r, input int a, input int pa, input int ex);
    chk({tag, ".v0"}, int'(m0.out_valid), v);
    chk({tag, ".v1"}, int'(m1.out_valid), v);
    chk({tag, ".r0"}, int'(m0.in_ready), r);
    chk({tag, ".r1"}, int'(m1.in_ready), r);
    chk({tag, ".a0"}, int'(m0.alpha_out), a);
    chk({tag, ".a1"}, int'(m1.alpha_out), a);
    chk({tag, ".pa0"}, int'(m0.pixel_achieved), pa);
    chk({tag, ".pa1"}, int'(m1.pixel_achieved), pa);
    chk({tag, ".ex0"}, int'(m0.exact), ex);
    chk({tag, ".ex1"}, int'(m1.exact), ex);
  endtask
  task automatic run(input string tag, input int p, input int t, input int ea, input int epa, input int eex, input int elat);
    int n, l0, l1, a0, a1, pa0, pa1, x0, x1;
    bit d0, d1;
    d0 = 0; d1 = 0; n = 0; l0 = 0; l1 = 0;
    a0 = 0; a1 = 0; pa0 = 0; pa1 = 0; x0 = 0; x1 = 0;
    @(negedge clk);
    chk({tag, ".rdy0"}, int'(m0.in_ready), 1);
    chk({tag, ".rdy1"}, int'(m1.in_ready), 1);
    pixel = 8'(p);
    target = 8'(t);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    while (!(d0 && d1) && n < 40) begin
      @(posedge clk);
      #1 n++;
      if (!d0 && m0.out_valid) begin
        d0 = 1; l0 = n; a0 = m0.alpha_out; pa0 = m0.pixel_achieved; x0 = m0.exact;
      end
      if (!d1 && m1.out_valid) begin
        d1 = 1; l1 = n; a1 = m1.alpha_out; pa1 = m1.pixel_achieved; x1 = m1.exact;
      end
    end
    chk({tag, ".done"}, int'(d0 && d1), 1);
    chk({tag, ".a0"}, a0, ea);
    chk({tag, ".a1"}, a1, ea);
    chk({tag, ".pa0"}, pa0, epa);
    chk({tag, ".pa1"}, pa1, epa);
    chk({tag, ".ex0"}, x0, eex);
    chk({tag, ".ex1"}, x1, eex);
    if (elat > 0) chk({tag, ".lat0"}, l0, elat);
    chk({tag, ".lat1"}, l1, 2 * l0);
    @(posedge clk);
  endtask
  initial begin
    int p, t, b, n;
    repeat (2) @(posedge clk);
    #1 outs("reset", 0, 1, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    run("p100t100", 100, 100, 50, 100, 1, 7);
    run("p100t50", 100, 50, 25, 50, 1, -1);
    run("p100t99", 100, 99, 50, 100, 0, -1);
    run("p0t255", 0, 255, 100, 255, 1, -1);
    run("p200t0", 200, 0, 0, 0, 1, -1);
    @(negedge clk);
    pixel = 8'd100;
    target = 8'd50;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!m1.out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("hold.reach", int'(m1.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 outs("hold", 1, 0, 25, 50, 1);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 outs("release", 0, 1, 25, 50, 1);
    run("b2b", 100, 99, 50, 100, 0, -1);
    @(negedge clk);
    pixel = 8'd0;
    target = 8'd255;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 outs("midrst", 0, 1, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    run("postrst", 0, 255, 100, 255, 1, -1);
    run("p255t255", 255, 255, best(255, 255), fm(255, best(255, 255)), 1, -1);
    for (int i = 0; i < 20; i++) begin
      p = int'($urandom_range(255));
      t = int'($urandom_range(255));
      b = best(p, t);
      run($sformatf("sweep%0d", i), p, t, b, fm(p, b), int'(fm(p, b) == t), -1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
